ddr4_sref_sequencer: RTL and testbench



---
 rtl/ddr4_sref_pkg.sv | 50 +++++
 rtl/sref_tmo_counter.sv | 44 ++++
 rtl/ddr4_sref_sequencer.sv | 139 +++++++++++++
 tb/tb_ddr4_sref_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr4_sref_pkg.sv
// ddr4_sref_pkg
//   Definitions shared by the DDR4 self-refresh sequencer and its helpers:
//   - sref_state_t : FSM state encoding, also visible on the `state` port.
//   - CTRL_* / STATUS_ACK : bit positions inside the sref control and
//     status words of the self-refresh control mapping stage.
//   - ctrl_decode() : control word that belongs to each state.
package ddr4_sref_pkg;

    typedef enum logic [2:0] {
        ST_INIT         = 3'd0,
        ST_IDLE         = 3'd1,
        ST_ENTER_WAIT   = 3'd2,
        ST_IN_SREF      = 3'd3,
        ST_EXIT_WAIT    = 3'd4,
        ST_RESTORE      = 3'd5,
        ST_RESTORE_CMPL = 3'd6,
        ST_ERROR        = 3'd7
    } sref_state_t;

    localparam int CTRL_REQ   = 0;
    localparam int CTRL_RCMPL = 2;
    localparam int CTRL_SKIP  = 3;
    localparam int CTRL_XSDB  = 4;
    localparam int STATUS_ACK = 7;

    // Control word driven while the FSM sits in state s. Bits 1 and 7:5 are
    // never set.
    function automatic logic [7:0] ctrl_decode(input sref_state_t s);
        logic [7:0] c;
        c = '0;
        case (s)
            ST_ENTER_WAIT,
            ST_IN_SREF: begin
                c[CTRL_REQ] = 1'b1;
            end
            ST_RESTORE: begin
                c[CTRL_SKIP] = 1'b1;
                c[CTRL_XSDB] = 1'b1;
            end
            ST_RESTORE_CMPL: begin
                c[CTRL_SKIP]  = 1'b1;
                c[CTRL_RCMPL] = 1'b1;
            end
            default: begin
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/sref_tmo_counter.sv
// sref_tmo_counter
//   Saturating up-counter used by the sequencer both as handshake timeout
//   timer and as restore-complete hold timer.
//   Ports:
//     clk    in   UI clock
//     rst    in   asynchronous active-high reset (count -> 0)
//     clr    in   synchronous clear to 0 (wins over en)
//     en     in   count enable
//     limit  in   terminal value compared against the current count
//     tc     out  count == limit
module sref_tmo_counter #(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             tc
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count;

    // Stick at all-ones instead of wrapping; a wrapped count could fake a
    // terminal-count match long after the awaited event was missed.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + ONE;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= sat_inc(count);
        end
    end

    assign tc = (count == limit);

endmodule

// File: rtl/ddr4_sref_sequencer.sv
// ddr4_sref_sequencer
//   Timed, timeout-guarded self-refresh enter/exit and boot calibration-
//   restore sequencer in front of the DDR4 self-refresh control mapping.
//   Parameters:
//     TMO_W         width of the timeout counter
//     TMO_CYCLES    cycles allowed for an ack edge before ERROR
//     RESTORE_HOLD  cycles restore_complete stays high (1..255)
//   Ports:
//     clk, rst      UI clock, asynchronous active-high reset
//     enter_req     pulse: enter self-refresh (accepted in IDLE only)
//     exit_req      pulse: exit self-refresh (accepted in IN_SREF only)
//     clear_err     pulse: leave ERROR once ack is low
//     boot_restore  strap: take the calibration-restore path after reset
//     restore_done  pulse: calibration data written back
//     sref_status   status word, bit 7 = self-refresh ack
//     sref_ctrl     control word (req, restore_complete, init skip, xsdb)
//     in_sref       self-refresh confirmed
//     busy          any state other than IDLE / IN_SREF
//     error         handshake timeout latched
//     state         current state encoding
module ddr4_sref_sequencer
    import ddr4_sref_pkg::*;
#(
    parameter int               TMO_W        = 20,
    parameter logic [TMO_W-1:0] TMO_CYCLES   = 20'd1000000,
    parameter int               RESTORE_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enter_req,
    input  logic       exit_req,
    input  logic       clear_err,
    input  logic       boot_restore,
    input  logic       restore_done,
    input  logic [7:0] sref_status,
    output logic [7:0] sref_ctrl,
    output logic       in_sref,
    output logic       busy,
    output logic       error,
    output logic [2:0] state
);

    // The counter is cleared on every state change, so it reads 0 in the
    // first cycle of a state; matching N-1 therefore means N cycles spent.
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_CYCLES - {{(TMO_W-1){1'b0}}, 1'b1};
    localparam logic [TMO_W-1:0] HOLD_LAST = TMO_W'(RESTORE_HOLD - 1);

    sref_state_t      state_q;
    sref_state_t      state_d;
    logic             ack_q;
    logic [TMO_W-1:0] cnt_limit;
    logic             cnt_clr;
    logic             cnt_tc;
    logic [7:0]       ctrl_d;
    logic             in_sref_d;
    logic             busy_d;
    logic             error_d;
    logic             status_unused;

    assign status_unused = ^sref_status[6:0];

    assign cnt_limit = (state_q == ST_RESTORE_CMPL) ? HOLD_LAST : TMO_LAST;
    assign cnt_clr   = (state_d != state_q);

    sref_tmo_counter #(
        .CNT_W (TMO_W)
    ) u_tmo (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (1'b1),
        .limit (cnt_limit),
        .tc    (cnt_tc)
    );

    // Next state plus Moore decodes of that next state, so the registered
    // outputs change on the same edge as the state register.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: begin
                state_d = boot_restore ? ST_RESTORE : ST_IDLE;
            end
            ST_IDLE: begin
                if (enter_req) state_d = ST_ENTER_WAIT;
            end
            ST_ENTER_WAIT: begin
                // ack is tested first so a late ack beats the timeout
                if (ack_q)       state_d = ST_IN_SREF;
                else if (cnt_tc) state_d = ST_ERROR;
            end
            ST_IN_SREF: begin
                if (exit_req) state_d = ST_EXIT_WAIT;
            end
            ST_EXIT_WAIT: begin
                if (!ack_q)      state_d = ST_IDLE;
                else if (cnt_tc) state_d = ST_ERROR;
            end
            ST_RESTORE: begin
                if (restore_done) state_d = ST_RESTORE_CMPL;
            end
            ST_RESTORE_CMPL: begin
                if (cnt_tc) state_d = ST_IDLE;
            end
            ST_ERROR: begin
                if (clear_err && !ack_q) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        ctrl_d    = ctrl_decode(state_d);
        in_sref_d = (state_d == ST_IN_SREF);
        busy_d    = !((state_d == ST_IDLE) || (state_d == ST_IN_SREF));
        error_d   = (state_d == ST_ERROR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_INIT;
            ack_q     <= 1'b0;
            sref_ctrl <= 8'h00;
            in_sref   <= 1'b0;
            busy      <= 1'b1;
            error     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ack_q     <= sref_status[STATUS_ACK];
            sref_ctrl <= ctrl_d;
            in_sref   <= in_sref_d;
            busy      <= busy_d;
            error     <= error_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_ddr4_sref_sequencer.sv
module tb_ddr4_sref_sequencer;

    localparam int TMO  = 8;
    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enter_req = 1'b0;
    logic       exit_req = 1'b0;
    logic       clear_err = 1'b0;
    logic       boot_restore = 1'b0;
    logic       restore_done = 1'b0;
    logic [7:0] sref_status = 8'h00;
    logic [7:0] sref_ctrl;
    logic       in_sref;
    logic       busy;
    logic       error;
    logic [2:0] state;

    ddr4_sref_sequencer #(
        .TMO_W        (20),
        .TMO_CYCLES   (20'd8),
        .RESTORE_HOLD (HOLD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enter_req    (enter_req),
        .exit_req     (exit_req),
        .clear_err    (clear_err),
        .boot_restore (boot_restore),
        .restore_done (restore_done),
        .sref_status  (sref_status),
        .sref_ctrl    (sref_ctrl),
        .in_sref      (in_sref),
        .busy         (busy),
        .error        (error),
        .state        (state)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int miss = 0;

    // Reference model: mode number as listed for each state, cycles spent
    // in the current mode, and the one-cycle-delayed view of the ack pin.
    int m_mode  = 0;
    int m_dwell = 0;
    bit m_ack   = 1'b0;

    typedef struct {
        bit         en;
        bit         ex;
        bit         ack;
        logic [2:0] st;
        logic [7:0] ctrl;
        bit         ins;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_ctrl(input int mode);
        case (mode)
            2, 3:    return 8'h01;
            5:       return 8'h18;
            6:       return 8'h0C;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_step();
        int nxt;
        nxt = m_mode;
        case (m_mode)
            0: nxt = boot_restore ? 5 : 1;
            1: if (enter_req) nxt = 2;
            2: begin
                if (m_ack) nxt = 3;
                else if (m_dwell == TMO - 1) nxt = 7;
            end
            3: if (exit_req) nxt = 4;
            4: begin
                if (!m_ack) nxt = 1;
                else if (m_dwell == TMO - 1) nxt = 7;
            end
            5: if (restore_done) nxt = 6;
            6: if (m_dwell == HOLD - 1) nxt = 1;
            7: if (clear_err && !m_ack) nxt = 1;
            default: nxt = 0;
        endcase
        m_dwell = (nxt != m_mode) ? 0 : m_dwell + 1;
        m_mode  = nxt;
        m_ack   = sref_status[7];
    endtask

    // One active edge: advance the model with the inputs the DUT sampled,
    // then compare every output just after the edge.
    task automatic tick();
        logic [13:0] act;
        logic [13:0] exp;
        @(posedge clk);
        model_step();
        #1;
        act = {state, sref_ctrl, in_sref, busy, error};
        exp = {3'(m_mode), exp_ctrl(m_mode), (m_mode == 3),
               !((m_mode == 1) || (m_mode == 3)), (m_mode == 7)};
        check("cycle", 32'(act), 32'(exp));
    endtask

    // Asserts reset between edges and checks that outputs drop at once.
    task automatic do_reset(input bit boot);
        @(negedge clk);
        #2;
        rst = 1'b1;
        boot_restore = boot;
        enter_req = 1'b0;
        exit_req = 1'b0;
        clear_err = 1'b0;
        restore_done = 1'b0;
        #1;
        m_mode = 0;
        m_dwell = 0;
        m_ack = 1'b0;
        check("rst_ctrl", 32'(sref_ctrl), 32'h00);
        check("rst_state", 32'(state), 32'd0);
        check("rst_flags", 32'({in_sref, busy, error}), 32'b010);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        //               en ex ack  st    ctrl   ins
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 3'd1, 8'h00, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 3'd1, 8'h00, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 3'd2, 8'h01, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 3'd2, 8'h01, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 3'd2, 8'h01, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 3'd2, 8'h01, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 3'd2, 8'h01, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 3'd2, 8'h01, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 3'd3, 8'h01, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 3'd3, 8'h01, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 3'd4, 8'h00, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 3'd4, 8'h00, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 3'd4, 8'h00, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 3'd1, 8'h00, 1'b0};

        // Enter / exit flow, illegal exit in IDLE, simultaneous requests.
        do_reset(1'b0);
        for (int i = 0; i < 14; i++) begin
            enter_req   = tbl[i].en;
            exit_req    = tbl[i].ex;
            sref_status = {tbl[i].ack, 7'b0};
            tick();
            check($sformatf("tbl%0d_state", i), 32'(state), 32'(tbl[i].st));
            check($sformatf("tbl%0d_ctrl", i), 32'(sref_ctrl), 32'(tbl[i].ctrl));
            check($sformatf("tbl%0d_in_sref", i), 32'(in_sref), 32'(tbl[i].ins));
        end
        enter_req = 1'b0;
        exit_req  = 1'b0;

        // Timeout: exactly TMO cycles in ENTER_WAIT, then ERROR.
        enter_req = 1'b1;
        tick();
        enter_req = 1'b0;
        for (int k = 1; k < TMO; k++) begin
            tick();
            check("tmo_wait_state", 32'(state), 32'd2);
        end
        tick();
        check("tmo_state", 32'(state), 32'd7);
        check("tmo_error", 32'(error), 32'd1);
        check("tmo_ctrl", 32'(sref_ctrl), 32'h00);

        // clear_err ignored while ack is high, honoured once it is low.
        sref_status = 8'h80;
        tick();
        tick();
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("clr_ack_hi", 32'(state), 32'd7);
        sref_status = 8'h00;
        tick();
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check("clr_ack_lo", 32'(state), 32'd1);

        // Ack reaches ack_q on the very cycle the timeout would fire.
        enter_req = 1'b1;
        tick();
        enter_req = 1'b0;
        repeat (6) tick();
        sref_status = 8'h80;
        tick();
        check("race_pre", 32'(state), 32'd2);
        tick();
        check("race_state", 32'(state), 32'd3);
        check("race_error", 32'(error), 32'd0);

        // Reset while in IN_SREF, released with the boot-restore strap set.
        do_reset(1'b1);
        sref_status = 8'h00;
        tick();
        check("boot_state", 32'(state), 32'd5);
        check("boot_ctrl", 32'(sref_ctrl), 32'h18);
        tick();
        restore_done = 1'b1;
        tick();
        restore_done = 1'b0;
        check("rcmpl_ctrl0", 32'(sref_ctrl), 32'h0C);
        for (int k = 1; k < HOLD; k++) begin
            tick();
            check("rcmpl_hold", 32'(sref_ctrl), 32'h0C);
        end
        tick();
        check("rcmpl_done_state", 32'(state), 32'd1);
        check("rcmpl_done_ctrl", 32'(sref_ctrl), 32'h00);

        // Randomised traffic against the model.
        do_reset(1'b0);
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset(1'($urandom_range(0, 1)));
            end
            enter_req    = ($urandom_range(0, 5) == 0);
            exit_req     = ($urandom_range(0, 5) == 0);
            clear_err    = ($urandom_range(0, 7) == 0);
            restore_done = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 5) == 0) sref_status[7] = ~sref_status[7];
            sref_status[6:0] = 7'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
